// File: rtl/riscv_pkg.sv
// Shared fetch-path types: datapath widths, the NOP filler instruction and the
// {pc, instr} entry that travels from fetch to decode.
package riscv_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO of fetch entries; clear discards all contents
// and takes priority over any same-cycle push or pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           din,
    input  logic                   pop,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push && !clear;
    assign w_do_pop  = pop && !clear && (r_count != '0);

    // Storage carries no reset: a slot is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one imem read per unstalled cycle, buffers returned
// {pc, instr} pairs and hands them to decode over valid/ready.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc,
    output logic               pc_stall,
    input  logic               flush,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               r_inflight;
    logic [PC_W-1:0]    r_pc_q;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W:0]     w_credit;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

    // Credit counts the in-flight read as an occupied slot, so a returning
    // read always has room; only registered terms feed the stall.
    assign w_credit = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign pc_stall = (w_credit >= (CNT_W + 1)'(DEPTH));

    assign w_issue   = rst && !pc_stall && !flush;
    assign imem_en   = w_issue;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= 1'b0;
            r_pc_q     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc_q <= pc;
            end
        end
    end

    assign w_push             = r_inflight && !flush;
    assign w_push_entry.pc    = r_pc_q;
    assign w_push_entry.instr = imem_rdata;
    assign w_pop              = if_valid && if_ready && !flush;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_push_entry),
        .pop   (w_pop),
        .clear (flush),
        .count (w_count),
        .head  (w_head)
    );

    assign if_valid = (w_count != '0);
    assign if_instr = if_valid ? w_head.instr : NOP_INSTR;
    assign if_pc    = if_valid ? w_head.pc : '0;

endmodule
